proc_control_fsm: RTL and testbench

- Control unit for the 16-bit bus processor: R0-R7, A, G/ALU and DIN share one bus.
- Fetches a 9-bit instruction from DIN under a Run handshake and holds it in an internal IR.
- Sequences each instruction over timesteps T0-T3, driving one-hot register enables, bus-source selects, ALU opcode and a one-cycle Done pulse.
- Replaces the combinational step decoding and free-running step counter with a registered state machine.

---
 rtl/proc_control_fsm_pkg.sv | 23 ++
 rtl/proc_control_fsm_if.sv | 20 ++
 rtl/proc_control_fsm_onehot_dec3.sv | 8 +
 rtl/proc_control_fsm.sv | 83 ++++++++
 tb/tb_proc_control_fsm.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/proc_control_fsm_pkg.sv
// proc_pkg: opcodes, state encoding and IR field positions for the bus processor control unit.
package proc_pkg;
  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;
  localparam int OP_MSB = 8;
  localparam int OP_LSB = 6;
  localparam int X_MSB  = 5;
  localparam int X_LSB  = 3;
  localparam int Y_MSB  = 2;
  localparam int Y_LSB  = 0;
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_T1   = 2'b01,
    ST_T2   = 2'b10,
    ST_T3   = 2'b11
  } state_e;
endpackage

// File: rtl/proc_control_fsm_if.sv
// proc_control_fsm_if: run handshake, instruction input and control outputs of the control unit.
interface proc_control_fsm_if #(parameter int DATA_W = 16, parameter int IR_W = 9);
  logic              Run;
  logic [DATA_W-1:0] DIN;
  logic [7:0]        Rin;
  logic [7:0]        Rout;
  logic              Ain;
  logic              Gin;
  logic              Gout;
  logic              DINout;
  logic [2:0]        AluOp;
  logic              Done;
  logic              Busy;
  logic [IR_W-1:0]   IRq;
  logic [DATA_W-1:0] InstrCount;
  modport master (output Run, DIN,
                  input Rin, Rout, Ain, Gin, Gout, DINout, AluOp, Done, Busy, IRq, InstrCount);
  modport slave  (input Run, DIN,
                  output Rin, Rout, Ain, Gin, Gout, DINout, AluOp, Done, Busy, IRq, InstrCount);
endinterface

// File: rtl/proc_control_fsm_onehot_dec3.sv
// onehot_dec3: 3-to-8 one-hot decoder, all zeros when disabled.
module onehot_dec3 (
  input  logic       en,
  input  logic [2:0] a,
  output logic [7:0] y
);
  assign y = en ? 8'b1 << a : 8'b0;
endmodule

// File: rtl/proc_control_fsm.sv
// proc_control_fsm: registered T0-T3 sequencer for the 16-bit bus processor.
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IR_W   = 9
) (
  input logic                 Clock,
  input logic                 Resetn,
  proc_control_fsm_if.slave   bus
);
  state_e            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [7:0]        x_oh, y_oh;
  logic [2:0]        op;
  logic              rin_x, rout_x, rout_y, ain, gin, gout, dinout, done;
  assign op = ir_q[OP_MSB:OP_LSB];
  onehot_dec3 u_x_dec (.en(state_q != ST_IDLE), .a(ir_q[X_MSB:X_LSB]), .y(x_oh));
  onehot_dec3 u_y_dec (.en(state_q != ST_IDLE), .a(ir_q[Y_MSB:Y_LSB]), .y(y_oh));
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    rin_x   = 1'b0;
    rout_x  = 1'b0;
    rout_y  = 1'b0;
    ain     = 1'b0;
    gin     = 1'b0;
    gout    = 1'b0;
    dinout  = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ir_d    = bus.Run ? bus.DIN[IR_W-1:0] : ir_q;
        state_d = bus.Run ? ST_T1 : ST_IDLE;
      end
      ST_T1: begin
        rout_y  = op == OP_MV;
        dinout  = op == OP_MVI;
        rout_x  = op != OP_MV && op != OP_MVI;
        ain     = rout_x;
        rin_x   = !rout_x;
        done    = !rout_x;
        state_d = rout_x ? ST_T2 : ST_IDLE;
      end
      ST_T2: begin
        rout_y  = 1'b1;
        gin     = 1'b1;
        state_d = ST_T3;
      end
      ST_T3: begin
        gout    = 1'b1;
        rin_x   = 1'b1;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cnt_d = cnt_q + DATA_W'(done);
  end
  always_ff @(posedge Clock) begin
    if (Resetn) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.Rin        = rin_x ? x_oh : 8'b0;
  assign bus.Rout       = rout_x ? x_oh : rout_y ? y_oh : 8'b0;
  assign bus.Ain        = ain;
  assign bus.Gin        = gin;
  assign bus.Gout       = gout;
  assign bus.DINout     = dinout;
  assign bus.AluOp      = op;
  assign bus.Done       = done;
  assign bus.Busy       = state_q != ST_IDLE;
  assign bus.IRq        = ir_q;
  assign bus.InstrCount = cnt_q;
endmodule

// File: tb/tb_proc_control_fsm.sv
// tb_proc_control_fsm: directed checks of fetch, mv/mvi/ALU sequencing, reset abort and counter wrap.
module tb_proc_control_fsm;
    logic Clock = 1'b0;
    logic Resetn;
    int   n_cmp = 0;
    int   n_bad = 0;
    proc_control_fsm_if #(.DATA_W(16), .IR_W(9)) bus ();
    proc_control_fsm #(.DATA_W(16), .IR_W(9)) dut (.Clock(Clock), .Resetn(Resetn), .bus(bus));
    always #5 Clock = ~Clock;

    logic [21:0] ctrl;
    assign ctrl = {bus.Rin, bus.Rout, bus.Ain, bus.Gin, bus.Gout, bus.DINout, bus.Done, bus.Busy};

    function automatic logic [21:0] ec(input logic [7:0] rin, input logic [7:0] rout,
                                       input logic ain, input logic gin, input logic gout,
                                       input logic dout, input logic done, input logic busy);
        return {rin, rout, ain, gin, gout, dout, done, busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Bus ownership and decode invariants, checked on every out-of-reset cycle.
    always @(negedge Clock) begin
        if (!Resetn) begin
            n_cmp++;
            assert ((32'(bus.Rout != 8'b0) + 32'(bus.DINout) + 32'(bus.Gout)) <= 1 &&
                    $onehot0(bus.Rin) && $onehot0(bus.Rout) &&
                    (32'(bus.Ain) + 32'(bus.Gin) + 32'(bus.Rin != 8'b0)) <= 1 &&
                    bus.AluOp === bus.IRq[8:6]) else begin
                n_bad++;
                $error("FAIL bus_excl: ctrl %0h aluop %0h ir %0h", ctrl, bus.AluOp, bus.IRq);
            end
        end
    end

    initial begin
        Resetn  = 1'b1;
        bus.Run = 1'b0;
        bus.DIN = 16'h0000;
        step();
        step();
        chk("rst_ctrl", 32'(ctrl), 32'(ec(8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
        chk("rst_ir", 32'(bus.IRq), 32'h0);
        Resetn = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("idle_ctrl", 32'(ctrl), 32'(ec(8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
        chk("idle_cnt", 32'(bus.InstrCount), 32'h0);
        // mv R2,R5
        bus.Run = 1'b1;
        bus.DIN = 16'h0015;
        step();
        bus.Run = 1'b0;
        chk("mv_t1", 32'(ctrl), 32'(ec(8'h04, 8'h20, 0, 0, 0, 0, 1, 1)));
        chk("mv_ir", 32'(bus.IRq), 32'h015);
        step();
        chk("mv_idle", 32'(ctrl), 32'(ec(8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
        chk("mv_cnt", 32'(bus.InstrCount), 32'h1);
        // mvi R3 with immediate on DIN during T1
        bus.Run = 1'b1;
        bus.DIN = 16'h0058;
        step();
        bus.Run = 1'b0;
        bus.DIN = 16'h1234;
        chk("mvi_t1", 32'(ctrl), 32'(ec(8'h08, 8'h00, 0, 0, 0, 1, 1, 1)));
        chk("mvi_ir", 32'(bus.IRq), 32'h058);
        step();
        chk("mvi_cnt", 32'(bus.InstrCount), 32'h2);
        chk("mvi_ir_hold", 32'(bus.IRq), 32'h058);
        // add R1,R2 twice back-to-back with Run held high
        bus.Run = 1'b1;
        bus.DIN = 16'h008A;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("add_t1", 32'(ctrl), 32'(ec(8'h00, 8'h02, 1, 0, 0, 0, 0, 1)));
            step();
            chk("add_t2", 32'(ctrl), 32'(ec(8'h00, 8'h04, 0, 1, 0, 0, 0, 1)));
            chk("add_aluop", 32'(bus.AluOp), 32'h2);
            step();
            chk("add_t3", 32'(ctrl), 32'(ec(8'h02, 8'h00, 0, 0, 1, 0, 1, 1)));
            if (k == 1) bus.Run = 1'b0;
            step();
            chk("add_idle", 32'(ctrl), 32'(ec(8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
            chk("add_cnt", 32'(bus.InstrCount), 32'(3 + k));
        end
        // sub R0,R7 with Run dropped in T2: still completes
        bus.Run = 1'b1;
        bus.DIN = 16'h00C7;
        step();
        chk("sub_t1", 32'(ctrl), 32'(ec(8'h00, 8'h01, 1, 0, 0, 0, 0, 1)));
        step();
        bus.Run = 1'b0;
        chk("sub_t2", 32'(ctrl), 32'(ec(8'h00, 8'h80, 0, 1, 0, 0, 0, 1)));
        chk("sub_aluop", 32'(bus.AluOp), 32'h3);
        step();
        chk("sub_t3", 32'(ctrl), 32'(ec(8'h01, 8'h00, 0, 0, 1, 0, 1, 1)));
        step();
        chk("sub_cnt", 32'(bus.InstrCount), 32'h5);
        chk("sub_idle", 32'(ctrl), 32'(ec(8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
        // sub again, reset asserted in T2 aborts it
        bus.Run = 1'b1;
        step();
        step();
        chk("abort_t2", 32'(ctrl), 32'(ec(8'h00, 8'h80, 0, 1, 0, 0, 0, 1)));
        Resetn  = 1'b1;
        bus.Run = 1'b0;
        step();
        chk("abort_ctrl", 32'(ctrl), 32'(ec(8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
        chk("abort_cnt", 32'(bus.InstrCount), 32'h0);
        chk("abort_ir", 32'(bus.IRq), 32'h0);
        Resetn = 1'b0;
        step();
        chk("abort_stay", 32'(ctrl), 32'(ec(8'h00, 8'h00, 0, 0, 0, 0, 0, 0)));
        // counter wrap: preload to all ones, then one mv R0,R0
        force dut.cnt_q = 16'hFFFF;
        step();
        release dut.cnt_q;
        chk("wrap_pre", 32'(bus.InstrCount), 32'hFFFF);
        bus.Run = 1'b1;
        bus.DIN = 16'h0000;
        step();
        bus.Run = 1'b0;
        chk("mv_same_t1", 32'(ctrl), 32'(ec(8'h01, 8'h01, 0, 0, 0, 0, 1, 1)));
        step();
        chk("wrap_cnt", 32'(bus.InstrCount), 32'h0);
        step();
        chk("wrap_hold", 32'(bus.InstrCount), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
